// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads the combinational
// instruction store and buffers {pc, instr} pairs for decode.
module imem_fetch_ctrl #(
  parameter logic [31:0] START_ADDR  = 32'h00400000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          QDEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [15:0] fetch_count
);

  localparam int          PW        = $clog2(QDEPTH);
  localparam logic [31:0] LAST_ADDR = START_ADDR + 32'(4 * (DEPTH_WORDS - 1));
  localparam logic [PW:0] FULL_CNT  = (PW + 1)'(QDEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          fault;
  logic [31:0]   fault_addr;
  logic [15:0]   push_cnt;

  logic pc_ok;
  logic full;
  logic pop;
  logic push;

  // Unsigned range and alignment check on the current fetch PC.
  assign pc_ok = (pc[1:0] == 2'b00) && (pc >= START_ADDR) && (pc <= LAST_ADDR);
  assign full  = (count == FULL_CNT);
  assign pop   = (count != '0) && if_ready;
  assign push  = (state == S_FETCH) && fetch_en && pc_ok && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= START_ADDR;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
      push_cnt   <= '0;
    end else if (redirect_valid) begin
      // Redirect flushes the queue and cancels any same-cycle push or pop.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= redirect_pc;
      fault  <= 1'b0;
      if (state == S_FAULT) begin
        state <= fetch_en ? S_FETCH : S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_en) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!fetch_en) begin
            state <= S_IDLE;
          end else if (!pc_ok) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_addr <= pc;
          end else if (push) begin
            pc <= pc + 32'd4;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (push_cnt != 16'hFFFF) begin
          push_cnt <= push_cnt + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && rst_n && !redirect_valid) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_instruction;
    end
  end

  assign imem_pc     = pc;
  assign if_valid    = (count != '0);
  assign if_instr    = if_valid ? q_instr[rd_ptr] : 32'd0;
  assign if_pc       = if_valid ? q_pc[rd_ptr] : 32'd0;
  assign fetch_fault = fault;
  assign fault_pc    = fault_addr;
  assign fetch_count = push_cnt;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed stimulus queues expected
// {pc, instr} pairs; a negedge monitor checks every accepted handshake.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] START = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_en         (fetch_en),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .fetch_fault      (fetch_fault),
    .fault_pc         (fault_pc),
    .fetch_count      (fetch_count)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h20080001 + ((a - START) >> 2);
  endfunction

  // Instruction store model: 64 words, junk outside the text segment.
  always_comb begin
    imem_instruction = 32'hDEADBEEF;
    if (imem_pc[1:0] == 2'b00 && imem_pc >= START && imem_pc <= START + 32'h000000FC)
      imem_instruction = word_at(imem_pc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = first + 32'(4 * i);
      exp_q.push_back({a, word_at(a)});
    end
  endtask

  // Monitor: a handshake seen at negedge is accepted at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_delivery: got pc %h instr %h expected none", if_pc, if_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          bad++;
          $display("FAIL delivery: got pc %h instr %h expected pc %h instr %h",
                   if_pc, if_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; if_ready = 1'b0;
    step(2);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_imem_pc", imem_pc, START);

    // Streaming fetch with decode always ready.
    rst_n = 1'b1;
    step(1);
    expect_run(START, 30);
    fetch_en = 1'b1; if_ready = 1'b1;
    step(1);
    check("first_valid_e1", 32'(if_valid), 32'd0);
    step(1);
    check("first_valid_e2", 32'(if_valid), 32'd1);
    check("first_if_pc", if_pc, START);
    check("first_if_instr", if_instr, 32'h20080001);
    step(6);
    check("stream_count", 32'(fetch_count), 32'd7);

    // Fresh start with decode stalled: queue fills, PC holds.
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    step(1);
    exp_q.delete();
    expect_run(START, 20);
    rst_n = 1'b1; fetch_en = 1'b1;
    step(5);
    check("stall_imem_pc", imem_pc, 32'h00400008);
    check("stall_count", 32'(fetch_count), 32'd2);
    check("stall_valid", 32'(if_valid), 32'd1);
    check("stall_head_pc", if_pc, START);
    if_ready = 1'b1;
    step(4);
    if_ready = 1'b0;
    step(4);

    // Redirect with a full queue.
    exp_q.delete();
    expect_run(32'h00400020, 56);
    redirect_valid = 1'b1; redirect_pc = 32'h00400020;
    step(1);
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(if_valid), 32'd0);
    check("redir_imem_pc", imem_pc, 32'h00400020);
    if_ready = 1'b1;
    step(70);
    check("end_fault", 32'(fetch_fault), 32'd1);
    check("end_fault_pc", fault_pc, 32'h00400100);
    check("end_drained", 32'(if_valid), 32'd0);
    check("end_all_delivered", 32'(exp_q.size()), 32'd0);

    // Recover from the fault.
    if_ready = 1'b0;
    expect_run(START, 10);
    redirect_valid = 1'b1; redirect_pc = START;
    step(1);
    redirect_valid = 1'b0; if_ready = 1'b1;
    check("recover_fault_clr", 32'(fetch_fault), 32'd0);
    step(3);
    check("recover_resumed", 32'(exp_q.size()) < 32'd10 ? 32'd1 : 32'd0, 32'd1);

    // Misaligned redirect target.
    if_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h00400002;
    exp_q.delete();
    step(1);
    redirect_valid = 1'b0;
    check("mis_fault_pre", 32'(fetch_fault), 32'd0);
    check("mis_valid_pre", 32'(if_valid), 32'd0);
    step(1);
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_fault_pc", fault_pc, 32'h00400002);
    check("mis_no_push", 32'(if_valid), 32'd0);

    // Below-base redirect target from the fault state.
    redirect_valid = 1'b1; redirect_pc = 32'h003FFFFC;
    step(1);
    redirect_valid = 1'b0;
    check("low_fault_pre", 32'(fetch_fault), 32'd0);
    step(1);
    check("low_fault", 32'(fetch_fault), 32'd1);
    check("low_fault_pc", fault_pc, 32'h003FFFFC);
    check("low_no_push", 32'(if_valid), 32'd0);

    // Reset mid-stream with two entries queued.
    redirect_valid = 1'b1; redirect_pc = START;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    check("pre_rst_valid", 32'(if_valid), 32'd1);
    check("pre_rst_head", if_pc, START);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_imem_pc", imem_pc, START);
    check("mid_rst_count", 32'(fetch_count), 32'd0);
    check("mid_rst_fault", 32'(fetch_fault), 32'd0);
    rst_n = 1'b1; fetch_en = 1'b0;
    step(2);
    check("idle_imem_pc", imem_pc, START);
    check("idle_valid", 32'(if_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
